// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment display path (scan controller,
// anode decoder, cathode decoder).
package ssd_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-data and scan-output bundle between the display top level and
// the scan controller.
interface ssd_scan_ctrl_if;
    import ssd_pkg::*;

    logic                           enable;
    logic [NUM_DIGITS*NIBBLE_W-1:0] data_in;
    logic [NUM_DIGITS-1:0]          digit_en;
    logic [NUM_DIGITS-1:0]          dp_in;
    idx_t                           refreshcounter;
    nibble_t                        digit_value;
    logic                           dp_out;
    logic                           blank;
    logic                           frame_start;

    modport master (
        output enable, data_in, digit_en, dp_in,
        input  refreshcounter, digit_value, dp_out, blank, frame_start
    );

    modport slave (
        input  enable, data_in, digit_en, dp_in,
        output refreshcounter, digit_value, dp_out, blank, frame_start
    );

endinterface

// File: rtl/ssd_scan_ctrl_dwell_counter.sv
// Terminal-count counter: counts 0..MAX-1 while enabled, wraps on terminal
// count; clear has priority over enable.
module ssd_dwell_counter #(
    parameter int unsigned MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] count;

    assign tc = (count == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment multiplexing scan controller: steps the digit index, drives
// the digit nibble/dp/blank and double-buffers display data per frame.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    ssd_scan_ctrl_if.slave bus
);

    localparam bit HAS_GAP = (BLANK_CYCLES > 0);

    state_t                         state, state_n;
    idx_t                           idx, idx_n;
    logic                           load, fs_n;
    logic [NUM_DIGITS*NIBBLE_W-1:0] sh_data, data_sel;
    logic [NUM_DIGITS-1:0]          sh_en, en_sel;
    logic [NUM_DIGITS-1:0]          sh_dp, dp_sel;
    logic                           blank_q, blank_n;
    nibble_t                        val_q, val_n;
    logic                           dp_q, dp_n;
    logic                           fs_q;
    logic                           dwell_tc, gap_tc;

    ssd_dwell_counter #(.MAX(PRESCALE)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.enable || (state != SHOW)),
        .en    (state == SHOW),
        .tc    (dwell_tc)
    );

    generate
        if (HAS_GAP) begin : g_gap
            ssd_dwell_counter #(.MAX(BLANK_CYCLES)) u_gap (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (!bus.enable || (state != GAP)),
                .en    (state == GAP),
                .tc    (gap_tc)
            );
        end else begin : g_nogap
            assign gap_tc = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            sh_data <= '0;
            sh_en   <= '0;
            sh_dp   <= '0;
            blank_q <= 1'b1;
            val_q   <= '0;
            dp_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            if (load) begin
                sh_data <= bus.data_in;
                sh_en   <= bus.digit_en;
                sh_dp   <= bus.dp_in;
            end
            blank_q <= blank_n;
            val_q   <= val_n;
            dp_q    <= dp_n;
            fs_q    <= fs_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        fs_n    = 1'b0;
        if (!bus.enable) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = '0;
                    load    = 1'b1;
                    fs_n    = 1'b1;
                end
                SHOW: begin
                    if (dwell_tc) begin
                        if (HAS_GAP) begin
                            state_n = GAP;
                        end else begin
                            idx_n = idx + 1'b1;
                            load  = (idx == IDX_W'(NUM_DIGITS - 1));
                            fs_n  = (idx == IDX_W'(NUM_DIGITS - 1));
                        end
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state_n = SHOW;
                        idx_n   = idx + 1'b1;
                        load    = (idx == IDX_W'(NUM_DIGITS - 1));
                        fs_n    = (idx == IDX_W'(NUM_DIGITS - 1));
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Registered outputs look through to the incoming data on a latch edge so
    // the first digit of a frame already shows the freshly latched values.
    always_comb begin
        data_sel = load ? bus.data_in  : sh_data;
        en_sel   = load ? bus.digit_en : sh_en;
        dp_sel   = load ? bus.dp_in    : sh_dp;
        blank_n  = (state_n != SHOW) || !en_sel[idx_n];
        val_n    = data_sel[idx_n*NIBBLE_W +: NIBBLE_W];
        dp_n     = dp_sel[idx_n];
    end

    assign bus.refreshcounter = idx;
    assign bus.digit_value    = val_q;
    assign bus.dp_out         = dp_q;
    assign bus.blank          = blank_q;
    assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: two instances (with and without blank slot) compared
// every cycle against a frame-time model, plus directed literal checks.
module tb_ssd_scan_ctrl;

    localparam int PRE    = 4;
    localparam int GAP_A  = 2;
    localparam int GAP_B  = 0;
    localparam int SLOT_A = PRE + GAP_A;
    localparam int SLOT_B = PRE + GAP_B;

    typedef struct {
        bit          active;
        int          t;
        logic [31:0] d;
        logic [7:0]  e;
        logic [7:0]  p;
    } model_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] val;
        logic       dp;
        logic       blank;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    bit   chk_on = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    model_t ma = '{active: 1'b0, t: 0, d: '0, e: '0, p: '0};
    model_t mb = '{active: 1'b0, t: 0, d: '0, e: '0, p: '0};

    ssd_scan_ctrl_if ifa ();
    ssd_scan_ctrl_if ifb ();

    assign ifb.enable   = ifa.enable;
    assign ifb.data_in  = ifa.data_in;
    assign ifb.digit_en = ifa.digit_en;
    assign ifb.dp_in    = ifa.dp_in;

    ssd_scan_ctrl #(.PRESCALE(PRE), .BLANK_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(ifa)
    );

    ssd_scan_ctrl #(.PRESCALE(PRE), .BLANK_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Model state is "cycles since the current frame latched"; everything
    // visible is derived from that time and the slot geometry.
    function automatic model_t mstep(model_t m, logic en, logic [31:0] d,
                                     logic [7:0] e, logic [7:0] p, int frame);
        model_t r = m;
        if (!en) begin
            r.active = 1'b0;
            r.t      = 0;
        end else begin
            if (!r.active) begin
                r.active = 1'b1;
                r.t      = 0;
            end else begin
                r.t = (r.t + 1) % frame;
            end
            if (r.t == 0) begin
                r.d = d;
                r.e = e;
                r.p = p;
            end
        end
        return r;
    endfunction

    function automatic exp_t mexp(model_t m, int slot);
        exp_t x;
        int   i;
        bit   lit;
        i       = m.active ? m.t / slot : 0;
        lit     = m.active && ((m.t % slot) < PRE);
        x.idx   = 3'(i);
        x.val   = m.d[i*4 +: 4];
        x.dp    = m.p[i];
        x.blank = !(lit && m.e[i]);
        x.fs    = m.active && (m.t == 0);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) ma = '{active: 1'b0, t: 0, d: '0, e: '0, p: '0};
        else        ma = mstep(ma, ifa.enable, ifa.data_in, ifa.digit_en, ifa.dp_in, 8 * SLOT_A);
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) mb = '{active: 1'b0, t: 0, d: '0, e: '0, p: '0};
        else        mb = mstep(mb, ifb.enable, ifb.data_in, ifb.digit_en, ifb.dp_in, 8 * SLOT_B);
    end

    always @(negedge clk) begin
        exp_t xa, xb;
        if (chk_on) begin
            xa = mexp(ma, SLOT_A);
            xb = mexp(mb, SLOT_B);
            chk("a.refreshcounter", 32'(ifa.refreshcounter), 32'(xa.idx));
            chk("a.digit_value",    32'(ifa.digit_value),    32'(xa.val));
            chk("a.dp_out",         32'(ifa.dp_out),         32'(xa.dp));
            chk("a.blank",          32'(ifa.blank),          32'(xa.blank));
            chk("a.frame_start",    32'(ifa.frame_start),    32'(xa.fs));
            chk("b.refreshcounter", 32'(ifb.refreshcounter), 32'(xb.idx));
            chk("b.digit_value",    32'(ifb.digit_value),    32'(xb.val));
            chk("b.dp_out",         32'(ifb.dp_out),         32'(xb.dp));
            chk("b.blank",          32'(ifb.blank),          32'(xb.blank));
            chk("b.frame_start",    32'(ifb.frame_start),    32'(xb.fs));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ifa.enable   = 1'b0;
        ifa.data_in  = 32'h7654_3210;
        ifa.digit_en = 8'hFF;
        ifa.dp_in    = 8'h81;
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk_on = 1'b1;
        cyc(3);
        chk("reset.blank", 32'(ifa.blank), 32'd1);
        chk("reset.rc", 32'(ifa.refreshcounter), 32'd0);
        chk("reset.value", 32'(ifa.digit_value), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        cyc(6);
        ifa.enable = 1'b1;

        // first frame: t counts cycles after the enable edge
        cyc(1);
        chk("start.rc", 32'(ifa.refreshcounter), 32'd0);
        chk("start.fs", 32'(ifa.frame_start), 32'd1);
        chk("start.blank", 32'(ifa.blank), 32'd0);
        chk("start.dp", 32'(ifa.dp_out), 32'd1);
        cyc(4);
        chk("gap.blank", 32'(ifa.blank), 32'd1);
        chk("b.step4.rc", 32'(ifb.refreshcounter), 32'd1);
        chk("b.step4.blank", 32'(ifb.blank), 32'd0);
        cyc(2);
        chk("slot1.rc", 32'(ifa.refreshcounter), 32'd1);
        chk("slot1.value", 32'(ifa.digit_value), 32'd1);
        chk("slot1.dp", 32'(ifa.dp_out), 32'd0);
        cyc(36);
        chk("slot7.value", 32'(ifa.digit_value), 32'd7);
        chk("slot7.dp", 32'(ifa.dp_out), 32'd1);
        cyc(6);
        chk("frame2.fs", 32'(ifa.frame_start), 32'd1);
        chk("frame2.rc", 32'(ifa.refreshcounter), 32'd0);

        // mid-frame data change must not show until the next frame
        cyc(18);
        ifa.data_in = 32'hFFFF_FFFF;
        cyc(12);
        chk("midframe.value5", 32'(ifa.digit_value), 32'd5);
        cyc(18);
        chk("frame3.value0", 32'(ifa.digit_value), 32'hF);
        ifa.digit_en = 8'hF0;
        cyc(12);
        chk("frame3.blank2", 32'(ifa.blank), 32'd0);
        cyc(36);
        chk("frame4.fs", 32'(ifa.frame_start), 32'd1);
        chk("frame4.blank0", 32'(ifa.blank), 32'd1);
        cyc(24);
        chk("frame4.blank4", 32'(ifa.blank), 32'd0);
        cyc(10);

        // digit 5 gap: drop enable, then restart
        ifa.enable = 1'b0;
        cyc(1);
        chk("disable.rc", 32'(ifa.refreshcounter), 32'd0);
        chk("disable.blank", 32'(ifa.blank), 32'd1);
        chk("disable.fs", 32'(ifa.frame_start), 32'd0);
        cyc(3);
        ifa.enable   = 1'b1;
        ifa.digit_en = 8'hFF;
        cyc(1);
        chk("reenable.fs", 32'(ifa.frame_start), 32'd1);
        chk("reenable.rc", 32'(ifa.refreshcounter), 32'd0);
        chk("reenable.blank", 32'(ifa.blank), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            ifa.enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0)  ifa.data_in  = $urandom;
            if ($urandom_range(0, 15) == 0) ifa.digit_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ifa.dp_in    = 8'($urandom);
            cyc(1);
        end

        // asynchronous reset mid-slot, checked before any clock edge
        ifa.enable = 1'b1;
        cyc(7);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("async.a.blank", 32'(ifa.blank), 32'd1);
        chk("async.a.rc", 32'(ifa.refreshcounter), 32'd0);
        chk("async.a.value", 32'(ifa.digit_value), 32'd0);
        chk("async.a.dp", 32'(ifa.dp_out), 32'd0);
        chk("async.a.fs", 32'(ifa.frame_start), 32'd0);
        chk("async.b.blank", 32'(ifb.blank), 32'd1);
        chk("async.b.rc", 32'(ifb.refreshcounter), 32'd0);
        chk("async.b.value", 32'(ifb.digit_value), 32'd0);
        cyc(2);
        rst_a = 1'b1;
        rst_b = 1'b1;
        cyc(20);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Multiplexing scan controller for the 8-digit seven-segment display. It sits directly upstream of the anode decoder: it generates the 3-bit refreshcounter digit index and the matching 4-bit digit value and decimal point for the cathode decoder. It also drives a blank strobe, which the top level ORs into the anode bus to suppress ghosting between digits. Display data is double-buffered once per frame so that a frame never shows mixed old and new values.

Parameters:
PRESCALE, 100000, clk cycles each digit is lit (1 kHz per digit at 100 MHz); must be >= 1
BLANK_CYCLES, 1000, clk cycles of forced blank after each digit; 0 = no blank slot

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark and idle
data_in  input  32  eight nibbles; digit k = data_in[4k+3:4k]
digit_en  input  8  per-digit enable; 0 = slot keeps its timing but stays blank
dp_in  input  8  per-digit decimal point, active-high
refreshcounter  output  3  current digit index, consumed by the anode decoder
digit_value  output  4  nibble for the current digit
dp_out  output  1  decimal point for the current digit
blank  output  1  1 = all anodes must be off
frame_start  output  1  one-cycle pulse when a new frame latches data

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - refreshcounter=0, digit_value=0, dp_out=0, blank=1, frame_start=0.
  - Shadow registers = 0, all counters = 0, state = IDLE.
- All outputs are registered. digit_value and dp_out always reflect the shadow registers at the current index.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - blank=1, index held at 0.
  - If enable=1, go to SHOW on the next edge. On that same edge: latch data_in, digit_en and dp_in into the shadows; index=0; frame_start=1 for one cycle.
- SHOW:
  - blank = ~shadow_en[index].
  - Dwell counter runs 0..PRESCALE-1.
  - At terminal count: go to GAP if BLANK_CYCLES>0, otherwise advance the index directly (stay in SHOW).
- GAP:
  - blank=1, index unchanged.
  - Gap counter runs 0..BLANK_CYCLES-1, then advance the index and return to SHOW.
- Index advance:
  - index+1, modulo 8.
  - On the 7->0 wrap, re-latch the shadows and pulse frame_start on the same edge where index becomes 0.
- Input sampling: data_in, digit_en and dp_in changes are ignored mid-frame; they are sampled only at frame start.
- enable=0 in any state:
  - Next edge: state=IDLE, blank=1, index=0, counters cleared, no frame_start.
  - Shadows keep their values.
  - Re-enable always restarts at digit 0 with a fresh latch.
- Slot and frame lengths:
  - Slot length = PRESCALE+BLANK_CYCLES cycles; frame length = 8 slots.
  - Disabled digits do not shorten the frame.
- Latency: enable sampled high at edge N gives refreshcounter=0, frame_start=1, and blank=~digit_en[0] after edge N.
- Widths:
  - Dwell counter is $clog2(PRESCALE+1) bits; gap counter is $clog2(BLANK_CYCLES+1) bits.
  - Counters compare for equality only; no overflow is possible.
- Reset asserted mid-frame clears everything immediately, asynchronously.

Decomposition:
- Package ssd_pkg:
  - NUM_DIGITS=8, IDX_W=3, NIBBLE_W=4.
  - State enum {IDLE, SHOW, GAP}.
  - Shared with the anode and cathode decoders.
- One natural sub-module: ssd_dwell_counter, a parameterised terminal-count counter with clear and enable, instantiated twice (dwell and gap).

Test Plan:
All scenarios use PRESCALE=4 and BLANK_CYCLES=2 unless noted.
- Reset, then enable=1 at cycle 10 -> cycle 11: refreshcounter=0, frame_start=1, blank=0; index steps 0..7 every 6 cycles; frame_start repeats every 48 cycles.
- data_in=0x76543210, dp_in=0x81 -> digit_value equals the index in each SHOW slot; dp_out=1 only at indices 0 and 7; blank=1 for exactly 2 cycles between slots.
- data_in changed to 0xFFFFFFFF at digit 3 -> digits 3..7 still show 3..7; the next frame shows F on all digits.
- digit_en=0xF0 -> blank=1 throughout slots 0-3; digits 4-7 lit; frame still 48 cycles.
- enable dropped during digit 5 GAP -> next cycle IDLE, blank=1, refreshcounter=0; re-enable restarts at digit 0 with frame_start=1.
- BLANK_CYCLES=0 -> index advances every 4 cycles, blank never 1 during the scan; rst_n pulsed low mid-slot -> outputs return to reset values without waiting for a clock edge.
